ccip_intr_scheduler: RTL and testbench
======================================

# ccip_intr_scheduler

Schedules user interrupt requests onto the AFU's CCI-P c1 TX channel and shares that channel with the AFU write datapath. It sits between the AFU logic and the FIU c1 TX port. It latches per-ID interrupt requests and issues them round-robin under c1 almost-full backpressure. It tracks each issued interrupt until its FIU response arrives and, optionally, flags responses that never arrive.

## Interface
Parameters:
- NUM_INTR, 4: number of interrupt IDs; fixed to 4 to match the 2-bit CCI-P interrupt ID.
- STARVE_LIMIT, 16: datapath-win cycles an eligible interrupt tolerates before it takes priority; range 1..255.
- TIMEOUT_CYCLES, 65535: response watchdog limit per ID; 16-bit.

Ports:
- Clk_400  in  1  core clock; all logic synchronous to it.
- SoftReset  in  1  synchronous, active-high reset.
- intr_req  in  4  one-cycle request pulse per interrupt ID.
- vc_sel  in  t_ccip_vc  VC placed in issued interrupt headers.
- dp_c1_tx  in  t_if_ccip_c1_Tx  datapath c1 request; held while stalled.
- dp_c1_stall  out  1  combinational; datapath request not accepted this cycle.
- c1TxAlmFull  in  1  FIU c1 almost-full.
- cp2af_sRxPort  in  t_if_ccip_Rx  FIU RX port; c1 responses used.
- af2cp_c1_tx  out  t_if_ccip_c1_Tx  registered c1 request to the FIU.
- intr_pending  out  4  ID requested, not yet issued.
- intr_busy  out  4  ID issued, response outstanding.
- intr_timeout  out  4  sticky watchdog expiry per ID.
- intr_spurious  out  1  sticky; interrupt response received for a non-busy ID.

## Operation
- Pending: intr_req[i] sets pending[i]. Repeated requests coalesce into one pending bit. Pending[i] clears when ID i issues, unless intr_req[i] is asserted in the same cycle, in which case it stays set.
- Eligible ID: pending[i] & ~busy[i] & ~c1TxAlmFull. An ID is never re-issued while busy.
- Round-robin: pointer resets to 0. Search starts at the pointer. After granting ID k, the pointer becomes (k+1) mod 4.
- Arbitration per cycle:
  - Datapath valid with no eligible ID: datapath passes.
  - Eligible ID with no datapath valid: interrupt issues.
  - Both: datapath wins and dp_c1_stall=0, unless starve_cnt==STARVE_LIMIT; then the interrupt wins and dp_c1_stall=1.
- starve_cnt (8-bit): increments on each cycle the datapath wins while an ID is eligible. Resets to 0 on any interrupt issue. Saturates at STARVE_LIMIT.
- The datapath path does not gate on c1TxAlmFull; the datapath owns its own almost-full compliance.
- Issued interrupt header: req_type=eREQ_INTR, id=k, vc_sel=vc_sel, reserved fields 0, data 0, valid 1. Busy[k] sets.
- Response: cp2af_sRxPort.c1.rspValid with resp_type eRSP_INTR and id j.
  - If busy[j]: busy[j] clears.
  - If not busy[j]: intr_spurious sets.
- Simultaneous response and new request for the same busy ID: busy clears and pending sets. The ID may issue next cycle.

## Timing
- Reset values: af2cp_c1_tx all 0 (valid 0); pending, busy, intr_timeout, starve_cnt, pointer, watchdogs all 0; intr_spurious 0.
- Latency:
  - intr_req to af2cp_c1_tx.valid: 2 cycles minimum (latch, then registered issue).
  - Datapath request to output: 1 cycle.
  - A response clears busy on the next clock edge.
- At most one c1 request per cycle. Output valid drops to 0 on idle cycles.
- c1TxAlmFull is sampled in the same cycle as the issue decision. When it is asserted, no new interrupt issues the following cycle.
- SoftReset mid-operation: all state clears within 1 cycle. Outstanding responses that arrive after reset count as spurious.

## Configuration
- INTR_SCHED_TIMEOUT_EN defined: each busy ID runs a 16-bit counter. When the counter reaches TIMEOUT_CYCLES, intr_timeout[i] sets (sticky until reset), busy[i] clears, and the counter zeroes. A late response for that ID then counts as spurious.
- INTR_SCHED_TIMEOUT_EN undefined: no counters; intr_timeout tied to 0; busy waits indefinitely.

## Test plan
- Single request: intr_req=4'b0100, no datapath traffic -> af2cp_c1_tx.valid 2 cycles later with id=2, intr_busy=4'b0100. Inject an eRSP_INTR id=2 response -> intr_busy=0.
- Round-robin: intr_req=4'b1111 in one cycle -> issues id 0,1,2,3 on consecutive cycles. A second burst after all responses starts at the pointer (0).
- Starvation: datapath valid every cycle with intr_req[1] pending -> 16 datapath writes pass. The 17th cycle issues the interrupt with dp_c1_stall=1, and the datapath request issues the cycle after.
- Backpressure and coalescing: c1TxAlmFull=1, intr_req[3] pulsed three times -> nothing issues. Deassert -> exactly one interrupt, id=3.
- Busy re-request: intr_req[0] while busy[0] -> no issue until the response arrives, then id 0 issues 1 cycle later. Response for idle ID 1 -> intr_spurious=1.
- Timeout (macro defined, TIMEOUT_CYCLES=100): issue id 2, withhold the response -> intr_timeout=4'b0100 after 100 busy cycles, busy clears. A late response sets intr_spurious.

Source files
------------

// File: rtl/ccip_intr_scheduler.sv
// CCI-P c1 interrupt scheduler: latches per-ID requests, issues them round-robin onto c1 TX,
// shares the channel with the AFU datapath. Optional response watchdog: INTR_SCHED_TIMEOUT_EN.
package ccip_if_pkg;
  typedef enum logic [1:0] {
    eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4, eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6
  } t_ccip_c1_rsp;

  typedef logic [1:0] t_ccip_intr_id;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    logic [1:0]   cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  // Same width as the memory header; overlays it on the c1 TX bus.
  typedef struct packed {
    logic [5:0]    rsvd2;
    t_ccip_vc      vc_sel;
    logic [3:0]    rsvd1;
    t_ccip_c1_req  req_type;
    logic [61:0]   rsvd0;
    t_ccip_intr_id id;
  } t_ccip_c1_ReqIntrHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_vc      vc_used;
    logic          rsvd1;
    logic          hit_miss;
    logic [3:0]    rsvd0;
    t_ccip_c1_rsp  resp_type;
    logic [13:0]   rsvd2;
    t_ccip_intr_id id;
  } t_ccip_c1_RspIntrHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [27:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module ccip_intr_scheduler
  import ccip_if_pkg::*;
#(
  parameter int NUM_INTR       = 4,
  parameter int STARVE_LIMIT   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                Clk_400,
  input  logic                SoftReset,
  input  logic [NUM_INTR-1:0] intr_req,
  input  t_ccip_vc            vc_sel,
  input  t_if_ccip_c1_Tx      dp_c1_tx,
  output logic                dp_c1_stall,
  input  logic                c1TxAlmFull,
  input  t_if_ccip_Rx         cp2af_sRxPort,
  output t_if_ccip_c1_Tx      af2cp_c1_tx,
  output logic [NUM_INTR-1:0] intr_pending,
  output logic [NUM_INTR-1:0] intr_busy,
  output logic [NUM_INTR-1:0] intr_timeout,
  output logic                intr_spurious
);
  localparam int ID_W = $clog2(NUM_INTR);

  logic [NUM_INTR-1:0] pend_vec, busy_vec, tmo_vec, spur_vec, elig, issue_vec, rsp_vec;
  logic [ID_W-1:0]     grant_id, ptr_q, ptr_d;
  logic                grant_vld, intr_win;
  logic [7:0]          starve_q, starve_d;
  logic                spurious_q, spurious_d;
  t_if_ccip_c1_Tx      tx_q, tx_d;
  t_ccip_c1_RspIntrHdr rsp_hdr;
  t_ccip_c1_ReqIntrHdr intr_hdr;
  logic                rsp_intr;
  logic                unused_rx;

  assign rsp_hdr  = t_ccip_c1_RspIntrHdr'(cp2af_sRxPort.c1.hdr);
  assign rsp_intr = cp2af_sRxPort.c1.rspValid && (rsp_hdr.resp_type == eRSP_INTR);
  assign unused_rx = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull, cp2af_sRxPort.c0,
                       rsp_hdr.vc_used, rsp_hdr.rsvd1, rsp_hdr.hit_miss, rsp_hdr.rsvd0, rsp_hdr.rsvd2};

  always_comb begin
    rsp_vec = '0;
    if (rsp_intr) rsp_vec[rsp_hdr.id] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INTR; gi++) begin : g_slot
      ccip_intr_slot #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot (
        .clk      (Clk_400),
        .rst      (SoftReset),
        .req      (intr_req[gi]),
        .issue    (issue_vec[gi]),
        .rsp      (rsp_vec[gi]),
        .pending  (pend_vec[gi]),
        .busy     (busy_vec[gi]),
        .timeout  (tmo_vec[gi]),
        .spurious (spur_vec[gi])
      );
    end
  endgenerate

  // Almost-full gates only interrupts; the datapath handles its own compliance.
  assign elig = pend_vec & ~busy_vec & {NUM_INTR{~c1TxAlmFull}};

  // Walk from the farthest offset back so the slot nearest the pointer wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int o = NUM_INTR - 1; o >= 0; o--) begin
      idx = ID_W'((int'(ptr_q) + o) % NUM_INTR);
      if (elig[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign intr_win    = grant_vld && (!dp_c1_tx.valid || (starve_q == 8'(STARVE_LIMIT)));
  assign dp_c1_stall = dp_c1_tx.valid && intr_win;

  always_comb begin
    issue_vec = '0;
    ptr_d     = ptr_q;
    starve_d  = starve_q;
    tx_d      = '0;
    intr_hdr  = '0;
    intr_hdr.vc_sel   = vc_sel;
    intr_hdr.req_type = eREQ_INTR;
    intr_hdr.id       = t_ccip_intr_id'(grant_id);
    if (intr_win) begin
      issue_vec[grant_id] = 1'b1;
      ptr_d      = (grant_id == ID_W'(NUM_INTR - 1)) ? '0 : grant_id + 1'b1;
      starve_d   = '0;
      tx_d.hdr   = t_ccip_c1_ReqMemHdr'(intr_hdr);
      tx_d.valid = 1'b1;
    end else begin
      if (dp_c1_tx.valid) tx_d = dp_c1_tx;
      if (dp_c1_tx.valid && grant_vld && (starve_q != 8'(STARVE_LIMIT)))
        starve_d = starve_q + 8'd1;
    end
    spurious_d = spurious_q | (|spur_vec);
  end

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      ptr_q      <= '0;
      starve_q   <= '0;
      tx_q       <= '0;
      spurious_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      starve_q   <= starve_d;
      tx_q       <= tx_d;
      spurious_q <= spurious_d;
    end
  end

  assign af2cp_c1_tx   = tx_q;
  assign intr_pending  = pend_vec;
  assign intr_busy     = busy_vec;
  assign intr_timeout  = tmo_vec;
  assign intr_spurious = spurious_q;
endmodule

// Per-ID state: pending latch, busy tracking and the optional response watchdog.
module ccip_intr_slot #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic issue,
  input  logic rsp,
  output logic pending,
  output logic busy,
  output logic timeout,
  output logic spurious
);
  logic pending_q, pending_d, busy_q, busy_d, rsp_hit, expire;

  assign rsp_hit  = rsp & busy_q;
  assign spurious = rsp & ~busy_q;

`ifdef INTR_SCHED_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // A response landing on the expiry cycle wins; the ID completes normally.
  always_comb begin
    expire    = busy_q & ~rsp_hit & (wd_q == 16'(TIMEOUT_CYCLES - 1));
    wd_d      = (busy_q & ~rsp_hit & ~expire) ? wd_q + 16'd1 : 16'd0;
    timeout_d = timeout_q | expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    pending_d = (pending_q & ~issue) | req;
    busy_d    = (busy_q | issue) & ~rsp_hit & ~expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign pending = pending_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_ccip_intr_scheduler.sv
// Bench for ccip_intr_scheduler: directed scenarios plus randomized traffic against a cycle model.
module tb_ccip_intr_scheduler;
  import ccip_if_pkg::*;

  localparam int SL  = 16;
  localparam int TMO = 100;

  logic           Clk_400 = 1'b0;
  logic           SoftReset;
  logic [3:0]     intr_req;
  t_ccip_vc       vc_sel;
  t_if_ccip_c1_Tx dp_c1_tx;
  logic           dp_c1_stall;
  logic           c1TxAlmFull;
  t_if_ccip_Rx    cp2af_sRxPort;
  t_if_ccip_c1_Tx af2cp_c1_tx;
  logic [3:0]     intr_pending, intr_busy, intr_timeout;
  logic           intr_spurious;

  always #5 Clk_400 = ~Clk_400;

  ccip_intr_scheduler #(.NUM_INTR(4), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset), .intr_req(intr_req), .vc_sel(vc_sel),
    .dp_c1_tx(dp_c1_tx), .dp_c1_stall(dp_c1_stall), .c1TxAlmFull(c1TxAlmFull),
    .cp2af_sRxPort(cp2af_sRxPort), .af2cp_c1_tx(af2cp_c1_tx), .intr_pending(intr_pending),
    .intr_busy(intr_busy), .intr_timeout(intr_timeout), .intr_spurious(intr_spurious)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [3:0]       m_pend, m_busy, m_tmo;
  bit             m_spur;
  int             m_ptr, m_starve;
  int             m_age[4];
  t_if_ccip_c1_Tx m_tx;
  bit             exp_stall, act_stall;

  function automatic t_if_ccip_c1_Tx rand_dp();
    t_if_ccip_c1_Tx t;
    t = '0;
    t.hdr.req_type = eREQ_WRLINE_I;
    t.hdr.vc_sel   = t_ccip_vc'(2'($urandom_range(0, 3)));
    t.hdr.address  = 42'({$urandom(), $urandom()});
    t.hdr.mdata    = 16'($urandom());
    for (int w = 0; w < 16; w++) t.data[w*32 +: 32] = $urandom();
    t.valid = 1'b1;
    return t;
  endfunction

  function automatic t_ccip_c1_ReqIntrHdr act_ih();
    return t_ccip_c1_ReqIntrHdr'(af2cp_c1_tx.hdr);
  endfunction

  task automatic set_rsp(input int j);
    t_ccip_c1_RspIntrHdr rh;
    rh = '0;
    rh.resp_type = eRSP_INTR;
    rh.id = 2'(j);
    cp2af_sRxPort.c1.hdr = t_ccip_c1_RspMemHdr'(rh);
    cp2af_sRxPort.c1.rspValid = 1'b1;
  endtask

  // One clock: predict from the spec rules, clock the DUT, commit the prediction.
  task automatic tick();
    bit [3:0] np, nb, nt, rspv;
    bit ns, win;
    int nptr, nst, k;
    int nage[4];
    t_if_ccip_c1_Tx ntx;
    t_ccip_c1_ReqIntrHdr ih;
    t_ccip_c1_RspIntrHdr rh;
    #1;
    np = m_pend; nb = m_busy; nt = m_tmo; ns = m_spur;
    nptr = m_ptr; nst = m_starve; nage = m_age; ntx = '0;
    k = -1;
    if (!c1TxAlmFull)
      for (int o = 0; o < 4; o++) begin
        int c;
        c = (m_ptr + o) % 4;
        if (k < 0 && m_pend[c] && !m_busy[c]) k = c;
      end
    win = (k >= 0) && (!dp_c1_tx.valid || m_starve == SL);
    exp_stall = dp_c1_tx.valid && win;
    if (win) begin
      ih = '0; ih.vc_sel = vc_sel; ih.req_type = eREQ_INTR; ih.id = 2'(k);
      ntx.hdr = t_ccip_c1_ReqMemHdr'(ih); ntx.valid = 1'b1;
      np[k] = 1'b0; nb[k] = 1'b1; nptr = (k + 1) % 4; nst = 0;
    end else begin
      if (dp_c1_tx.valid) ntx = dp_c1_tx;
      if (dp_c1_tx.valid && k >= 0 && nst < SL) nst++;
    end
    rspv = '0;
    rh = t_ccip_c1_RspIntrHdr'(cp2af_sRxPort.c1.hdr);
    if (cp2af_sRxPort.c1.rspValid && rh.resp_type == eRSP_INTR) begin
      if (m_busy[rh.id]) rspv[rh.id] = 1'b1;
      else ns = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (rspv[i]) begin
        nb[i] = 1'b0; nage[i] = 0;
      end
`ifdef INTR_SCHED_TIMEOUT_EN
      else if (m_busy[i]) begin
        if (m_age[i] + 1 == TMO) begin
          nb[i] = 1'b0; nt[i] = 1'b1; nage[i] = 0;
        end else nage[i] = m_age[i] + 1;
      end
`endif
    end
    np |= intr_req;
    if (SoftReset) begin
      np = '0; nb = '0; nt = '0; ns = 1'b0; nptr = 0; nst = 0; ntx = '0;
      for (int i = 0; i < 4; i++) nage[i] = 0;
    end
    act_stall = dp_c1_stall;
    @(posedge Clk_400);
    #1;
    m_pend = np; m_busy = nb; m_tmo = nt; m_spur = ns;
    m_ptr = nptr; m_starve = nst; m_age = nage; m_tx = ntx;
    intr_req = '0;
    cp2af_sRxPort.c1.rspValid = 1'b0;
  endtask

  task automatic do_reset();
    SoftReset = 1'b1;
    intr_req = '0; dp_c1_tx = '0; c1TxAlmFull = 1'b0; cp2af_sRxPort = '0;
    tick(); tick();
    SoftReset = 1'b0;
  endtask

  task automatic test_reset();
    SoftReset = 1'b1;
    intr_req = 4'b1111; dp_c1_tx = rand_dp(); c1TxAlmFull = 1'b0; cp2af_sRxPort = '0;
    set_rsp(1);
    tick(); tick();
    SoftReset = 1'b0; dp_c1_tx = '0;
    checks++;
    if (af2cp_c1_tx !== '0 || intr_pending !== 4'b0 || intr_busy !== 4'b0 ||
        intr_timeout !== 4'b0 || intr_spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx_v=%b hdr=%h pend=%b busy=%b tmo=%b spur=%b, want all zero",
               af2cp_c1_tx.valid, af2cp_c1_tx.hdr, intr_pending, intr_busy, intr_timeout, intr_spurious);
    end
  endtask

  task automatic test_single();
    do_reset();
    vc_sel = eVC_VH1;
    intr_req = 4'b0100;
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b0 || intr_pending !== 4'b0100) begin
      errors++;
      $display("FAIL single_latch: valid=%b pend=%b, want valid=0 pend=0100", af2cp_c1_tx.valid, intr_pending);
    end
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b1 || act_ih().id !== 2'd2 || act_ih().req_type !== eREQ_INTR ||
        act_ih().vc_sel !== eVC_VH1 || af2cp_c1_tx.data !== '0 || intr_busy !== 4'b0100 ||
        intr_pending !== 4'b0) begin
      errors++;
      $display("FAIL single_issue: valid=%b id=%0d type=%0d vc=%0d busy=%b pend=%b, want 1 id=2 type=6 vc=3 busy=0100 pend=0000",
               af2cp_c1_tx.valid, act_ih().id, act_ih().req_type, act_ih().vc_sel, intr_busy, intr_pending);
    end
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: valid=%b, want 0", af2cp_c1_tx.valid);
    end
    set_rsp(2);
    tick();
    checks++;
    if (intr_busy !== 4'b0 || intr_spurious !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: busy=%b spur=%b, want 0000 0", intr_busy, intr_spurious);
    end
    vc_sel = eVC_VL0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      intr_req = 4'b1111;
      tick();
      for (int n = 0; n < 4; n++) begin
        tick();
        checks++;
        if (af2cp_c1_tx.valid !== 1'b1 || act_ih().id !== 2'(n) || act_ih().req_type !== eREQ_INTR) begin
          errors++;
          $display("FAIL rr_burst%0d_slot%0d: valid=%b id=%0d, want valid=1 id=%0d",
                   b, n, af2cp_c1_tx.valid, act_ih().id, n);
        end
      end
      tick();
      checks++;
      if (af2cp_c1_tx.valid !== 1'b0 || intr_busy !== 4'b1111) begin
        errors++;
        $display("FAIL rr_after_burst%0d: valid=%b busy=%b, want 0 1111", b, af2cp_c1_tx.valid, intr_busy);
      end
      for (int j = 0; j < 4; j++) begin
        set_rsp(j);
        tick();
      end
      checks++;
      if (intr_busy !== 4'b0 || intr_spurious !== 1'b0) begin
        errors++;
        $display("FAIL rr_drain%0d: busy=%b spur=%b, want 0000 0", b, intr_busy, intr_spurious);
      end
    end
  endtask

  task automatic test_starvation();
    t_if_ccip_c1_Tx cur;
    bit prev_stall;
    do_reset();
    intr_req = 4'b0010;
    tick();
    prev_stall = 1'b0;
    cur = '0;
    for (int c = 0; c < 18; c++) begin
      if (!prev_stall) cur = rand_dp();
      dp_c1_tx = cur;
      tick();
      prev_stall = act_stall;
      checks++;
      if (c == 16) begin
        if (act_stall !== 1'b1 || af2cp_c1_tx.valid !== 1'b1 || act_ih().req_type !== eREQ_INTR ||
            act_ih().id !== 2'd1) begin
          errors++;
          $display("FAIL starve_intr_wins: stall=%b valid=%b type=%0d id=%0d, want stall=1 valid=1 type=6 id=1",
                   act_stall, af2cp_c1_tx.valid, act_ih().req_type, act_ih().id);
        end
      end else if (act_stall !== 1'b0 || af2cp_c1_tx !== cur) begin
        errors++;
        $display("FAIL starve_dp_cycle%0d: stall=%b hdr=%h, want stall=0 hdr=%h",
                 c, act_stall, af2cp_c1_tx.hdr, cur.hdr);
      end
    end
    dp_c1_tx = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    c1TxAlmFull = 1'b1;
    for (int p = 0; p < 3; p++) begin
      intr_req = 4'b1000;
      tick(); tick();
      checks++;
      if (af2cp_c1_tx.valid !== 1'b0 || intr_pending !== 4'b1000) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b pend=%b, want 0 1000", p, af2cp_c1_tx.valid, intr_pending);
      end
    end
    c1TxAlmFull = 1'b0;
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b1 || act_ih().id !== 2'd3) begin
      errors++;
      $display("FAIL bp_release: valid=%b id=%0d, want 1 id=3", af2cp_c1_tx.valid, act_ih().id);
    end
    for (int q = 0; q < 3; q++) begin
      tick();
      checks++;
      if (af2cp_c1_tx.valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_single%0d: valid=%b, want 0", q, af2cp_c1_tx.valid);
      end
    end
  endtask

  task automatic test_busy_rereq();
    do_reset();
    intr_req = 4'b0001;
    tick(); tick();
    intr_req = 4'b0001;
    tick();
    for (int q = 0; q < 3; q++) tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b0 || intr_busy !== 4'b0001 || intr_pending !== 4'b0001) begin
      errors++;
      $display("FAIL rereq_blocked: valid=%b busy=%b pend=%b, want 0 0001 0001",
               af2cp_c1_tx.valid, intr_busy, intr_pending);
    end
    set_rsp(0);
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b0 || intr_busy !== 4'b0) begin
      errors++;
      $display("FAIL rereq_rsp: valid=%b busy=%b, want 0 0000", af2cp_c1_tx.valid, intr_busy);
    end
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b1 || act_ih().id !== 2'd0 || intr_busy !== 4'b0001) begin
      errors++;
      $display("FAIL rereq_issue: valid=%b id=%0d busy=%b, want 1 id=0 0001",
               af2cp_c1_tx.valid, act_ih().id, intr_busy);
    end
    set_rsp(0);
    intr_req = 4'b0001;
    tick();
    checks++;
    if (intr_busy !== 4'b0 || intr_pending !== 4'b0001) begin
      errors++;
      $display("FAIL rsp_req_same_cycle: busy=%b pend=%b, want 0000 0001", intr_busy, intr_pending);
    end
    tick();
    checks++;
    if (af2cp_c1_tx.valid !== 1'b1 || act_ih().id !== 2'd0 || intr_spurious !== 1'b0) begin
      errors++;
      $display("FAIL rsp_req_reissue: valid=%b id=%0d spur=%b, want 1 id=0 0",
               af2cp_c1_tx.valid, act_ih().id, intr_spurious);
    end
    set_rsp(1);
    tick();
    checks++;
    if (intr_spurious !== 1'b1 || intr_busy !== 4'b0001) begin
      errors++;
      $display("FAIL spurious_idle_id: spur=%b busy=%b, want 1 0001", intr_spurious, intr_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    intr_req = 4'b0001;
    tick(); tick();
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
    checks++;
    if (intr_busy !== 4'b0 || af2cp_c1_tx.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: busy=%b valid=%b, want 0000 0", intr_busy, af2cp_c1_tx.valid);
    end
    set_rsp(0);
    tick();
    checks++;
    if (intr_spurious !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_late_rsp: spur=%b, want 1", intr_spurious);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    intr_req = 4'b0100;
    tick(); tick();
`ifdef INTR_SCHED_TIMEOUT_EN
    for (int t = 1; t < TMO; t++) tick();
    checks++;
    if (intr_busy !== 4'b0100 || intr_timeout !== 4'b0) begin
      errors++;
      $display("FAIL timeout_before: busy=%b tmo=%b, want 0100 0000", intr_busy, intr_timeout);
    end
    tick();
    checks++;
    if (intr_busy !== 4'b0 || intr_timeout !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_expire: busy=%b tmo=%b, want 0000 0100", intr_busy, intr_timeout);
    end
    set_rsp(2);
    tick();
    checks++;
    if (intr_spurious !== 1'b1 || intr_timeout !== 4'b0100 || af2cp_c1_tx.valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_rsp: spur=%b tmo=%b valid=%b, want 1 0100 0",
               intr_spurious, intr_timeout, af2cp_c1_tx.valid);
    end
`else
    for (int t = 0; t < TMO + 20; t++) tick();
    checks++;
    if (intr_busy !== 4'b0100 || intr_timeout !== 4'b0) begin
      errors++;
      $display("FAIL no_watchdog: busy=%b tmo=%b, want 0100 0000", intr_busy, intr_timeout);
    end
`endif
  endtask

  task automatic test_random();
    t_if_ccip_c1_Tx cur;
    do_reset();
    cur = '0;
    for (int c = 0; c < 600; c++) begin
      if (!exp_stall) begin
        cur = rand_dp();
        cur.valid = ($urandom_range(0, 1) == 1);
      end
      dp_c1_tx = cur;
      vc_sel = t_ccip_vc'(2'($urandom_range(0, 3)));
      c1TxAlmFull = ($urandom_range(0, 3) == 0);
      intr_req = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0;
      if (m_busy != 0 && $urandom_range(0, 3) == 0) begin
        int j;
        j = $urandom_range(0, 3);
        while (!m_busy[j]) j = (j + 1) % 4;
        set_rsp(j);
      end else if ($urandom_range(0, 99) < 2) set_rsp($urandom_range(0, 3));
      tick();
      checks++;
      if (act_stall !== exp_stall || af2cp_c1_tx !== m_tx || intr_pending !== m_pend ||
          intr_busy !== m_busy || intr_spurious !== m_spur || intr_timeout !== m_tmo) begin
        errors++;
        $display("FAIL random_cyc%0d: stall=%b v=%b hdr=%h pend=%b busy=%b spur=%b tmo=%b, want stall=%b v=%b hdr=%h pend=%b busy=%b spur=%b tmo=%b",
                 c, act_stall, af2cp_c1_tx.valid, af2cp_c1_tx.hdr, intr_pending, intr_busy, intr_spurious,
                 intr_timeout, exp_stall, m_tx.valid, m_tx.hdr, m_pend, m_busy, m_spur, m_tmo);
      end
    end
    dp_c1_tx = '0;
    c1TxAlmFull = 1'b0;
  endtask

  initial begin
    SoftReset = 1'b1;
    intr_req = '0; vc_sel = eVC_VL0; dp_c1_tx = '0; c1TxAlmFull = 1'b0; cp2af_sRxPort = '0;
    m_pend = '0; m_busy = '0; m_tmo = '0; m_spur = 1'b0; m_ptr = 0; m_starve = 0; m_tx = '0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
    exp_stall = 1'b0; act_stall = 1'b0;
    @(posedge Clk_400);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_backpressure();
    test_busy_rereq();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
